// File: rtl/chia_tanso_param.sv
// chia_tanso_param: a prescaled counter with a runtime-loadable divisor.
// A prescaler makes a BASE_HZ strobe. A modulo-N counter advances on that strobe.
// The divided output is either a pulse at each wrap or a toggle at each wrap.
// A new divisor waits in a pending register until the next wrap or clear,
// so the count never jumps past the terminal value of the divisor in force.
module chia_tanso_param #(
  parameter int CLK_HZ    = 50000000,
  parameter int BASE_HZ   = 10,
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 10
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  input  logic             mode,
  output logic             base_tick,
  output logic [DIV_W-1:0] count,
  output logic             wrap,
  output logic             clk_out
);

  localparam int               PRESCALE  = CLK_HZ / BASE_HZ;
  localparam int               PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRESC_ONE = PW'(1);
  localparam logic [DIV_W-1:0] DIV_INIT  = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);

  logic [PW-1:0]    presc;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_pend;
  logic             pend_valid;

  logic strobe;
  logic at_last;
  logic wrap_edge;
  logic load_ok;

  // Decode the prescaler strobe, the terminal count and a usable divisor load.
  // ">=" keeps the counter bounded even if the count is ever out of range.
  always_comb begin
    strobe    = en && (presc == PRESC_MAX);
    at_last   = (count >= (div_act - DIV_ONE));
    wrap_edge = strobe && at_last;
    load_ok   = div_load && (div_in != DIV_ZERO);
  end

  // Prescaler and base_tick: the prescaler holds while en is low.
  // base_tick is the registered strobe.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      base_tick <= 1'b0;
    end else if (clr) begin
      presc     <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= strobe;
      if (strobe) begin
        presc <= '0;
      end else if (en) begin
        presc <= presc + PRESC_ONE;
      end else begin
        presc <= presc;
      end
    end
  end

  // Digit counter and wrap pulse: the counter advances once per strobe.
  // It returns to 0 after N-1, and wrap marks that return.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= wrap_edge;
      if (wrap_edge) begin
        count <= '0;
      end else if (strobe) begin
        count <= count + DIV_ONE;
      end else begin
        count <= count;
      end
    end
  end

  // Divisor handling: a load is parked as pending and promoted only at a wrap or a clear.
  // A load that coincides with a wrap is applied directly.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      div_act    <= DIV_INIT;
      div_pend   <= DIV_INIT;
      pend_valid <= 1'b0;
    end else if (clr) begin
      if (pend_valid) begin
        div_act <= div_pend;
      end else begin
        div_act <= div_act;
      end
      pend_valid <= 1'b0;
    end else if (wrap_edge) begin
      if (load_ok) begin
        div_act <= div_in;
      end else if (pend_valid) begin
        div_act <= div_pend;
      end else begin
        div_act <= div_act;
      end
      pend_valid <= 1'b0;
    end else if (load_ok) begin
      div_pend   <= div_in;
      pend_valid <= 1'b1;
    end else begin
      div_pend   <= div_pend;
      pend_valid <= pend_valid;
    end
  end

  // Divided output: in pulse mode it follows the wrap pulse.
  // In toggle mode it flips at each wrap, so it holds while en is low.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      clk_out <= 1'b0;
    end else if (clr) begin
      clk_out <= 1'b0;
    end else if (mode) begin
      clk_out <= wrap_edge ? ~clk_out : clk_out;
    end else begin
      clk_out <= wrap_edge;
    end
  end

endmodule
